// File: rtl/fdl_reverb_pkg.sv
// Shared types and helpers for the feedback-delay-line reverb.
package fdl_reverb_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int C_GAIN_FRAC   = 15;
  localparam int C_MIN_DELAY   = 4;
  localparam int C_SAT_WIDTH   = 64;

  // Clamp a wide signed value into the range of a signed number of the given width.
  function automatic logic signed [C_SAT_WIDTH-1:0] saturate(
    input logic signed [C_SAT_WIDTH-1:0] value,
    input int                            width
  );
    logic signed [C_SAT_WIDTH-1:0] maxVal;
    logic signed [C_SAT_WIDTH-1:0] minVal;
    maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
    minVal = -maxVal - 64'sd1;
    if (value > maxVal) begin
      saturate = maxVal;
    end else if (value < minVal) begin
      saturate = minVal;
    end else begin
      saturate = value;
    end
  endfunction

endpackage

// File: rtl/fdl_delay_ram.sv
// Simple dual-port delay RAM with a registered, enable-gated read port.
module fdl_delay_ram
  import fdl_reverb_pkg::*;
#(
  parameter int G_DEPTH      = 32,
  parameter int G_WIDTH      = 24,
  parameter int G_ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    wrEn_i,
  input  logic [G_ADDR_WIDTH-1:0] wrAddr_i,
  input  logic [G_WIDTH-1:0]      wrData_i,
  input  logic                    rdEn_i,
  input  logic [G_ADDR_WIDTH-1:0] rdAddr_i,
  output logic [G_WIDTH-1:0]      rdData_o
);

  logic [G_WIDTH-1:0] mem [G_DEPTH];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
  end

  // Read port: holds its word while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rdEn_i) begin
      rdData_o <= mem[rdAddr_i];
    end
  end

endmodule

// File: rtl/fdl_reverb.sv
// Multichannel feedback-delay-line reverb: three-stage pipeline around a shared
// delay RAM, with self-clearing of the RAM after reset or re-enable.
module fdl_reverb
  import fdl_reverb_pkg::*;
#(
  parameter int G_NUM_CHANNELS     = 2,
  parameter int G_DATA_WIDTH       = 24,
  parameter int G_DELAY_DEPTH_LOG2 = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           bypass,
  input  logic [G_DELAY_DEPTH_LOG2-1:0]  delay_len,
  input  logic [15:0]                    feedback_gain,
  input  logic [15:0]                    wet_gain,
  input  logic [15:0]                    dry_gain,
  input  logic signed [G_DATA_WIDTH-1:0] din,
  input  logic                           din_valid,
  output logic                           din_ready,
  input  logic                           din_last,
  output logic signed [G_DATA_WIDTH-1:0] dout,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           dout_last,
  output logic                           sat_flag,
  output logic                           frame_err
);

  localparam int N     = G_NUM_CHANNELS;
  localparam int W     = G_DATA_WIDTH;
  localparam int D     = G_DELAY_DEPTH_LOG2;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = CW + D;
  localparam int DEPTH = N * (2 ** D);
  localparam int PW    = W + 17;

  state_t               stateQ, stateD;
  logic [AW-1:0]        clrCntQ, clrCntD;
  logic                 softClear, advance, accept;

  logic [CW-1:0]        chQ, chD;
  logic [D-1:0]         wpQ, wpD, lenQ, lenD;
  logic [D-1:0]         newLen, lenUse, wpUse;
  logic                 lastCh, frameEnd;
  logic                 frameErrQ, frameErrD;

  logic                 s1ValidQ, s1LastQ;
  logic signed [W-1:0]  s1XQ;
  logic [AW-1:0]        s1AddrQ;

  logic                 s2ValidQ, s2LastQ;
  logic signed [W-1:0]  s2XQ;
  logic [AW-1:0]        s2AddrQ;
  logic signed [PW-1:0] fbProdQ, dryProdQ, wetProdQ;

  logic signed [PW-1:0] yExt, xExt, fbExt, wetExt, dryExt;
  logic signed [63:0]   fbSum, mixSum, vSat, outSat;
  logic                 vOvf, outOvf;

  logic                 doutValidQ, doutLastQ, satFlagQ;
  logic signed [W-1:0]  doutQ;

  logic                 ramWrEn;
  logic [AW-1:0]        ramWrAddr, ramRdAddr;
  logic [W-1:0]         ramWrData, ramRdData;

  assign softClear = reset | ~enable;
  assign advance   = ~doutValidQ | dout_ready;
  assign din_ready = (stateQ == ST_RUN) & enable & advance;
  assign accept    = din_valid & din_ready;

  // Next-state logic: sweep every RAM address once in CLEAR, then run forever.
  always_comb begin
    stateD  = stateQ;
    clrCntD = clrCntQ;
    case (stateQ)
      ST_CLEAR: begin
        clrCntD = clrCntQ + AW'(1);
        if (clrCntQ == AW'(DEPTH - 1)) begin
          stateD = ST_RUN;
        end
      end
      default: begin
        stateD = ST_RUN;
      end
    endcase
  end

  // State register; reset and enable-low both restart the RAM sweep.
  always_ff @(posedge clk) begin
    if (softClear) begin
      stateQ  <= ST_CLEAR;
      clrCntQ <= '0;
    end else begin
      stateQ  <= stateD;
      clrCntQ <= clrCntD;
    end
  end

  // A new length only takes effect at a frame boundary, pulling wp back if needed.
  assign lastCh   = (chQ == CW'(N - 1));
  assign frameEnd = lastCh | din_last;
  assign newLen   = (delay_len < D'(C_MIN_DELAY)) ? D'(C_MIN_DELAY) : delay_len;
  assign lenUse   = (chQ == '0) ? newLen : lenQ;
  assign wpUse    = (wpQ >= lenUse) ? '0 : wpQ;
  assign ramRdAddr = {chQ, wpUse};

  // Channel/frame bookkeeping; an early din_last closes the frame and is flagged.
  always_comb begin
    chD       = chQ;
    wpD       = wpQ;
    lenD      = lenQ;
    frameErrD = frameErrQ;
    if (accept) begin
      lenD = lenUse;
      if (frameEnd) begin
        chD = '0;
        wpD = (wpUse >= lenUse - D'(1)) ? '0 : wpUse + D'(1);
      end else begin
        chD = chQ + CW'(1);
        wpD = wpUse;
      end
      if (din_last && !lastCh) begin
        frameErrD = 1'b1;
      end
    end
  end

  // Frame pointer, channel counter, sampled length and sticky framing flag.
  always_ff @(posedge clk) begin
    if (softClear) begin
      chQ       <= '0;
      wpQ       <= '0;
      lenQ      <= D'(C_MIN_DELAY);
      frameErrQ <= 1'b0;
    end else begin
      chQ       <= chD;
      wpQ       <= wpD;
      lenQ      <= lenD;
      frameErrQ <= frameErrD;
    end
  end

  assign yExt   = PW'($signed(ramRdData));
  assign xExt   = PW'(s1XQ);
  assign fbExt  = PW'({1'b0, feedback_gain});
  assign wetExt = PW'({1'b0, wet_gain});
  assign dryExt = PW'({1'b0, dry_gain});

  // Valid bits of the two internal stages; dropped on reset so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (softClear) begin
      s1ValidQ <= 1'b0;
      s2ValidQ <= 1'b0;
    end else if (advance) begin
      s1ValidQ <= accept;
      s2ValidQ <= s1ValidQ;
    end
  end

  // Stage payloads: S1 holds the accepted sample, S2 holds the three products.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1XQ     <= din;
      s1AddrQ  <= ramRdAddr;
      s1LastQ  <= lastCh;
      s2XQ     <= s1XQ;
      s2AddrQ  <= s1AddrQ;
      s2LastQ  <= s1LastQ;
      fbProdQ  <= yExt * fbExt;
      dryProdQ <= xExt * dryExt;
      wetProdQ <= yExt * wetExt;
    end
  end

  // Final sums with floor shifts, then clamp to the sample range.
  always_comb begin
    fbSum  = 64'(s2XQ) + 64'(fbProdQ >>> C_GAIN_FRAC);
    mixSum = (64'(dryProdQ) + 64'(wetProdQ)) >>> C_GAIN_FRAC;
    vSat   = saturate(fbSum, W);
    outSat = saturate(mixSum, W);
    vOvf   = (vSat != fbSum);
    outOvf = (outSat != mixSum);
  end

  // RAM write source: zeros during the sweep, feedback sum when S2 retires.
  always_comb begin
    ramWrEn   = 1'b0;
    ramWrAddr = s2AddrQ;
    ramWrData = vSat[W-1:0];
    if (stateQ == ST_CLEAR) begin
      ramWrEn   = 1'b1;
      ramWrAddr = clrCntQ;
      ramWrData = '0;
    end else if (s2ValidQ && advance && !softClear) begin
      ramWrEn = 1'b1;
    end
  end

  // Output register and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (softClear) begin
      doutValidQ <= 1'b0;
      doutQ      <= '0;
      doutLastQ  <= 1'b0;
      satFlagQ   <= 1'b0;
    end else begin
      if (advance) begin
        doutValidQ <= s2ValidQ;
        if (s2ValidQ) begin
          doutQ     <= bypass ? s2XQ : outSat[W-1:0];
          doutLastQ <= s2LastQ;
        end
      end
      if (s2ValidQ && advance && (vOvf || (outOvf && !bypass))) begin
        satFlagQ <= 1'b1;
      end
    end
  end

  assign dout       = doutQ;
  assign dout_valid = doutValidQ;
  assign dout_last  = doutLastQ;
  assign sat_flag   = satFlagQ;
  assign frame_err  = frameErrQ;

  fdl_delay_ram #(
    .G_DEPTH      (DEPTH),
    .G_WIDTH      (W),
    .G_ADDR_WIDTH (AW)
  ) delayRam (
    .clk      (clk),
    .wrEn_i   (ramWrEn),
    .wrAddr_i (ramWrAddr),
    .wrData_i (ramWrData),
    .rdEn_i   (advance),
    .rdAddr_i (ramRdAddr),
    .rdData_o (ramRdData)
  );

endmodule

// File: tb/tb_fdl_reverb.sv
// Directed bench for fdl_reverb: clear timing, impulse echoes, saturation,
// framing errors, backpressure against a small golden model, mid-stream reset.
module tb_fdl_reverb;

  localparam int N = 2;
  localparam int W = 24;
  localparam int D = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b1;
  logic                bypass = 1'b0;
  logic [D-1:0]        delay_len = 4'd4;
  logic [15:0]         feedback_gain = 16'h4000;
  logic [15:0]         wet_gain = 16'h8000;
  logic [15:0]         dry_gain = 16'h8000;
  logic signed [W-1:0] din = '0;
  logic                din_valid = 1'b0;
  logic                din_ready;
  logic                din_last = 1'b0;
  logic signed [W-1:0] dout;
  logic                dout_valid;
  logic                dout_ready = 1'b1;
  logic                dout_last;
  logic                sat_flag;
  logic                frame_err;

  int                  checkCount = 0;
  int                  passCount = 0;
  int                  cycleCnt = 0;
  int                  firstInCycle = -1;
  int                  firstOutCycle = -1;
  int                  readyPhase = 0;
  logic                bpMode = 1'b0;
  logic                gapMode = 1'b0;
  logic                stallPending = 1'b0;
  logic signed [W-1:0] stallData = '0;
  logic signed [W-1:0] outData[$];
  logic                outLast[$];

  fdl_reverb #(
    .G_NUM_CHANNELS     (N),
    .G_DATA_WIDTH       (W),
    .G_DELAY_DEPTH_LOG2 (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .bypass        (bypass),
    .delay_len     (delay_len),
    .feedback_gain (feedback_gain),
    .wet_gain      (wet_gain),
    .dry_gain      (dry_gain),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .din_last      (din_last),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_last     (dout_last),
    .sat_flag      (sat_flag),
    .frame_err     (frame_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Output consumer: always ready normally, ready one cycle in three under backpressure.
  always @(posedge clk) begin
    #1;
    readyPhase = (readyPhase + 1) % 3;
    dout_ready = bpMode ? (readyPhase == 0) : 1'b1;
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Monitor: collect output handshakes and verify dout holds while stalled.
  always @(negedge clk) begin
    if (stallPending && !reset) begin
      checkOutput("stallValid", dout_valid, 1);
      checkOutput("stallData", dout, stallData);
    end
    stallPending = dout_valid && !dout_ready && !reset;
    stallData = dout;
    if (dout_valid && dout_ready) begin
      outData.push_back(dout);
      outLast.push_back(dout_last);
      if (firstOutCycle < 0) firstOutCycle = cycleCnt;
    end
    if (din_valid && din_ready && firstInCycle < 0) firstInCycle = cycleCnt;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, observed hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint satModel(input longint v);
    if (v > 64'sd8388607) return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  task automatic applyStimulus(input logic signed [W-1:0] x, input logic last);
    int guard;
    if (gapMode) begin
      din_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    din = x;
    din_last = last;
    din_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!din_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!din_ready) checkOutput("acceptTimeout", 0, 1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic sendFrame(input logic signed [W-1:0] x0, input logic signed [W-1:0] x1);
    applyStimulus(x0, 1'b0);
    applyStimulus(x1, 1'b1);
  endtask

  task automatic waitOutputs(input int n, input string tag);
    int guard;
    guard = 0;
    while (outData.size() < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (8) @(negedge clk);
    checkOutput(tag, outData.size(), n);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    int lowCount;
    logic sawValid;
    din_valid = 1'b0;
    din_last = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstDoutValid", dout_valid, 0);
    checkOutput("rstDinReady", din_ready, 0);
    checkOutput("rstDout", dout, 0);
    checkOutput("rstDoutLast", dout_last, 0);
    checkOutput("rstSatFlag", sat_flag, 0);
    checkOutput("rstFrameErr", frame_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    lowCount = 0;
    sawValid = 1'b0;
    @(negedge clk);
    while (!din_ready && lowCount < 100) begin
      lowCount++;
      if (dout_valid) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("clearCycles", lowCount, 32);
    checkOutput("clearNoValid", sawValid, 0);
    @(posedge clk);
    #1;
    outData.delete();
    outLast.delete();
  endtask

  task automatic impulseSetup();
    delay_len = 4'd4;
    feedback_gain = 16'h4000;
    wet_gain = 16'h8000;
    dry_gain = 16'h8000;
    outData.delete();
    outLast.delete();
    firstInCycle = -1;
    firstOutCycle = -1;
  endtask

  task automatic runImpulse(input string tag);
    int impTbl[16];
    longint expVal;
    impTbl = '{1000, 0, 0, 0, 1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0};
    impulseSetup();
    for (int f = 0; f < 16; f++) sendFrame((f == 0) ? 24'sd1000 : 24'sd0, 24'sd0);
    waitOutputs(32, {tag, "_count"});
    checkOutput({tag, "_latency"}, firstOutCycle - firstInCycle, 3);
    for (int i = 0; i < 32 && i < outData.size(); i++) begin
      expVal = (i % 2 == 0) ? longint'(impTbl[i / 2]) : 0;
      checkOutput($sformatf("%s_f%0d_ch%0d", tag, i / 2, i % 2), outData[i], expVal);
      checkOutput($sformatf("%s_last_f%0d_ch%0d", tag, i / 2, i % 2), outLast[i], i % 2);
    end
  endtask

  initial begin
    int satIn[9];
    int satExp[9];
    longint mem[N][16];
    longint expQ[$];
    longint y;
    longint v;
    int wp;
    logic signed [W-1:0] xs;

    doReset();

    // Impulse response with 0.5 feedback and unity wet/dry.
    runImpulse("imp");
    checkOutput("impNoSat", sat_flag, 0);
    checkOutput("impNoFrameErr", frame_err, 0);

    // Saturation: full-scale input on top of a pending echo.
    doReset();
    impulseSetup();
    satIn = '{1000, 0, 0, 0, 8388607, 0, 0, 0, 0};
    satExp = '{1000, 0, 0, 0, 8388607, 0, 0, 0, 8388607};
    for (int f = 0; f < 4; f++) sendFrame(W'(satIn[f]), 24'sd0);
    waitOutputs(8, "satCountA");
    checkOutput("satBefore", sat_flag, 0);
    for (int f = 4; f < 9; f++) sendFrame(W'(satIn[f]), 24'sd0);
    waitOutputs(18, "satCountB");
    checkOutput("satAfter", sat_flag, 1);
    for (int i = 0; i < 18 && i < outData.size(); i++) begin
      checkOutput($sformatf("sat_f%0d_ch%0d", i / 2, i % 2), outData[i],
                  (i % 2 == 0) ? longint'(satExp[i / 2]) : 0);
    end
    repeat (5) @(negedge clk);
    checkOutput("satSticky", sat_flag, 1);
    @(posedge clk);
    #1;

    // Framing: early din_last on channel 0.
    doReset();
    impulseSetup();
    feedback_gain = 16'h0000;
    checkOutput("frameErrClean", frame_err, 0);
    applyStimulus(24'sd100, 1'b1);
    applyStimulus(24'sd200, 1'b0);
    applyStimulus(24'sd300, 1'b1);
    waitOutputs(3, "frameCount");
    checkOutput("frameErrSet", frame_err, 1);
    if (outData.size() >= 3) begin
      checkOutput("frameVal0", outData[0], 100);
      checkOutput("frameVal1", outData[1], 200);
      checkOutput("frameVal2", outData[2], 300);
      checkOutput("frameLast0", outLast[0], 0);
      checkOutput("frameLast1", outLast[1], 0);
      checkOutput("frameLast2", outLast[2], 1);
    end

    // Backpressure with random input gaps against a behavioural model.
    doReset();
    delay_len = 4'd5;
    feedback_gain = 16'h6000;
    wet_gain = 16'h3000;
    dry_gain = 16'h5000;
    foreach (mem[c, a]) mem[c][a] = 0;
    expQ.delete();
    wp = 0;
    bpMode = 1'b1;
    gapMode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < N; c++) begin
        xs = W'($urandom);
        y = mem[c][wp];
        v = satModel(longint'(xs) + ((y * 24576) >>> 15));
        mem[c][wp] = v;
        expQ.push_back(satModel((longint'(xs) * 20480 + y * 12288) >>> 15));
        applyStimulus(xs, (c == N - 1));
      end
      wp = (wp == 4) ? 0 : wp + 1;
    end
    waitOutputs(40, "bpCount");
    for (int i = 0; i < 40 && i < outData.size(); i++) begin
      checkOutput($sformatf("bp_%0d", i), outData[i], expQ[i]);
      checkOutput($sformatf("bp_last_%0d", i), outLast[i], i % 2);
    end
    bpMode = 1'b0;
    gapMode = 1'b0;

    // Reset in the middle of an impulse decay, then repeat the impulse.
    doReset();
    impulseSetup();
    for (int f = 0; f < 10; f++) sendFrame((f == 0) ? 24'sd1000 : 24'sd0, 24'sd0);
    doReset();
    runImpulse("rerun");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fdl_reverb.md
# fdl_reverb

- Multichannel feedback-delay-line reverb with programmable delay length, feedback gain and wet/dry mix.
- Samples arrive channel-interleaved on an AXI-stream-style interface and leave on one. Arithmetic saturates throughout.
- Sits in the tulip_dsp effects chain and has no FIR core dependency.
- Each channel owns a private region of one shared delay RAM. The block clears the RAM itself after reset or re-enable.

## Interface
- G_NUM_CHANNELS, 2: interleaved channels per frame (1..8).
- G_DATA_WIDTH, 24: signed sample width W.
- G_DELAY_DEPTH_LOG2, 10: per-channel delay capacity is 2^D samples.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  low acts as a synchronous soft reset.
- bypass  in  1  forces dry-only output; the delay line keeps updating.
- delay_len  in  D  per-channel delay in frames; values <4 are clamped to 4.
- feedback_gain  in  16  1.15 unsigned.
- wet_gain  in  16  1.15 unsigned.
- dry_gain  in  16  1.15 unsigned.
- din  in  W  input sample, signed.
- din_valid  in  1  input valid.
- din_ready  out  1  input ready.
- din_last  in  1  marks the last channel of a frame.
- dout  out  W  output sample, signed.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.
- dout_last  out  1  set on the sample of channel N-1.
- sat_flag  out  1  sticky; any saturation since the last clear.
- frame_err  out  1  sticky; din_last seen on a channel other than N-1.

## Operation
- States are CLEAR and RUN.
  - Reset, or enable low, forces CLEAR and flushes the pipeline.
  - CLEAR writes zero to all N·2^D RAM addresses, one per cycle, then enters RUN.
- Channel counter ch runs 0..N-1 and increments on each accepted sample. Frame pointer wp advances when ch=N-1 is accepted.
  - wp wraps to 0 after delay_len_eff-1.
  - delay_len is sampled only when ch=0 is accepted, so changes never split a frame.
  - If wp ≥ a newly sampled length, wp resets to 0.
- RAM address is {ch, wp}.
- Per sample x:
  - y = ram[ch][wp].
  - v = sat(x + ((y·feedback_gain) >>> 15)); v is written to the same address.
  - out = sat(((x·dry_gain) + (y·wet_gain)) >>> 15).
  - In bypass, out = x.
- Width rules:
  - Each product is W+17 bits signed, with the gain zero-extended to 17 bits.
  - The shift is arithmetic (floor).
  - sat clamps to [-2^(W-1), 2^(W-1)-1] and sets sat_flag.
- din_last with ch≠N-1: the sample is processed as ch, frame_err is set, and the next sample is ch=0 with wp advanced.
- sat_flag and frame_err clear only on reset or enable low.

## Timing
- Reset values:
  - din_ready=0, dout_valid=0, dout=0, dout_last=0, sat_flag=0, frame_err=0.
  - ch=0, wp=0, state CLEAR.
- CLEAR lasts exactly N·2^D cycles after reset deasserts. din_ready may rise on the next cycle.
- Pipeline has 3 stages:
  - S0: accept and RAM read.
  - S1: multiplies.
  - S2: sum, saturate, RAM write and output register.
- Latency is 3 cycles from the din handshake to dout_valid, with dout_ready held high. Throughput is 1 sample per cycle.
- Stall rule: all stages advance only when the output register is empty or dout_ready=1.
  - din_ready = RUN & enable & advance.
  - dout holds stable while dout_valid=1 and dout_ready=0.
- Hazard: with the delay_len clamp of 4 there is never a same-address read in flight behind a pending write, so no bypass mux is needed.
- Reset mid-stream: dout_valid=0 on the next cycle, in-flight samples are dropped, and CLEAR restarts.
- Simultaneous din handshake and dout handshake in the same cycle is legal and loses nothing.

## Structure
- fdl_reverb_pkg holds:
  - the state enum;
  - C_GAIN_FRAC=15;
  - a parametrised saturate function;
  - a minimum-delay constant of 4.
- fdl_delay_ram sub-module: simple dual-port RAM, depth N·2^D, width W, 1-cycle registered read, write-first not required.

## Test plan
(N=2, W=24, D=4 unless stated.)
- Clear: release reset -> din_ready low for exactly 32 cycles, then high; dout_valid stays 0 throughout.
- Impulse: delay_len=4, fb=0x4000, wet=dry=0x8000; ch0 receives 1000 then zeros, ch1 zeros -> ch0 outputs 1000 at frame 0, 1000 at frame 4, 500 at frame 8, 250 at frame 12, 0 elsewhere; ch1 all 0; dout_last on every ch1 sample.
- Saturation: continue the impulse setup with ch0 x=0x7FFFFF at frame 4 -> dout=0x7FFFFF, sat_flag=1 and remains 1.
- Backpressure: random din_valid, dout_ready high 1 cycle in 3 -> output sequence equals a golden model exactly; no drops or duplicates; dout stable while stalled.
- Framing: din_last on a ch0 sample -> frame_err=1; the following sample appears on dout as ch0 with dout_last=0.
- Reset mid-stream: assert reset during impulse decay -> dout_valid=0 next cycle, 32-cycle clear, then the repeated impulse test gives results identical to the impulse scenario with no residual echo.
